mem_arb: RTL
============

# mem_arb

Sequential arbiter that shares a single-port unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (DM: lw/sw). Accepts one request at a time, holds the memory port for a fixed MEM_LAT cycles, and returns registered read data with a one-cycle valid pulse. Sits between the pipeline stage registers and the memory; the controller's MemRead/MemWrite drive `dm_req`/`dm_we`.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until `if_gnt`
- if_addr  in  AW  fetch address; stable while `if_req` is high
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_valid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  DW  fetched instruction
- dm_req  in  1  data request; held until `dm_gnt`
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_valid  out  1  one-cycle pulse: load data valid / store complete
- dm_rdata  out  DW  load data; 0 for stores
- mem_en  out  1  memory port active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched store data
- mem_rdata  in  DW  memory read data, valid in last busy cycle
- busy  out  1  access in flight (state ≠ IDLE)

## Operation
- States: IDLE, BUSY_IF, BUSY_DM. A 4-bit counter `cnt` counts busy cycles.
- IDLE: selects the winner among the requests that are asserted. `*_gnt` is high for the winner only. Next state is BUSY_IF or BUSY_DM. Address, we and wdata are latched into the `mem_*` registers, and `cnt` is loaded with MEM_LAT-1.
- No request: stay in IDLE, all gnt low.
- BUSY_x: `mem_en`=1, with `mem_we`=latched we (0 for IF). `cnt` decrements each cycle.
- When `cnt`==0, `mem_rdata` is registered into `x_rdata` (DM stores register 0), `x_valid` is set for the next cycle, and the FSM returns to IDLE.
- No grants while busy. A request arriving during busy waits and is arbitrated on return to IDLE.
- Fixed priority (default): DM wins ties, because a stalled MEM stage blocks the whole pipeline.
- `*_rdata` holds its value until the next valid for the same port.
- Reset values: state IDLE, `cnt` 0, `mem_en`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, both valid 0, both rdata 0, `busy` 0. The gnt outputs are 0 because they are gated by `rst`.
- Reset mid-access: the FSM aborts immediately. `mem_en`/`mem_we` drop asynchronously, no valid is issued, and the requester must re-request.

## Timing
- Request seen in IDLE at cycle T → gnt high in cycle T. Busy occupies T+1..T+MEM_LAT. valid pulses in T+MEM_LAT+1, and the FSM is IDLE again in that same cycle, so the next gnt can occur in T+MEM_LAT+1.
- Throughput: one access per MEM_LAT+1 cycles.
- Request-to-valid latency: MEM_LAT+1 cycles.
- `mem_addr`/`mem_we`/`mem_wdata` are stable for the whole busy window. A store commits in every busy cycle with identical data, which is idempotent.
- Simultaneous requests: exactly one gnt per cycle, never both.
- `x_valid` and a new `x_gnt` may be high in the same cycle.
- MEM_LAT=1: single busy cycle, `cnt` loaded 0.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on ties. A 1-bit `last` register records the port of the most recent grant; on a tie the other port wins. `last` resets to IF, so the first tie goes to DM. Single requests are granted regardless of `last`.
- Not defined: fixed DM-over-IF priority, and the `last` register is absent.

## Test plan
- Reset, then IF-only request addr 0x0000_0004 with mem_rdata=0x0000_0013 and MEM_LAT=2 → if_gnt at T, mem_en T+1..T+2, if_valid at T+3 with if_rdata=0x0000_0013.
- DM store addr 0x100, wdata 0xDEAD_BEEF → mem_we=1 and mem_addr=0x100 for 2 cycles, dm_valid at T+3, dm_rdata=0.
- IF and DM both requesting continuously, fixed priority → DM granted every arbitration and IF starves. With `MEM_ARB_RR_EN`: grants alternate DM, IF, DM, IF.
- IF request arrives while BUSY_DM → no if_gnt until dm_valid cycle, then if_gnt in that same cycle.
- Assert rst in second busy cycle of a load → mem_en drops asynchronously, no dm_valid ever, state IDLE. Re-request completes normally.
- MEM_LAT=1 back-to-back IF fetches 0x0, 0x4, 0x8 → a grant every 2 cycles, with if_valid values matching the memory model in order.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bundles the fetch, data and memory-side signals of the mem_arb arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb.sv
// Shares one single-port I/D memory between fetch and load/store, one access per MEM_LAT+1 cycles.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed DM-over-IF priority.
module mem_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);
  localparam int unsigned CW = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_valid_q, if_valid_d;
  logic          dm_valid_q, dm_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic idle, dm_win, if_win, if_gnt_c, dm_gnt_c;

  assign idle = (state_q == ST_IDLE);

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;  // 1 = most recent grant went to DM

  always_comb begin
    last_d = last_q;
    if (dm_gnt_c)      last_d = 1'b1;
    else if (if_gnt_c) last_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end

  assign dm_win = bus.dm_req & ~(bus.if_req & last_q);
`else
  assign dm_win = bus.dm_req;
`endif

  assign if_win   = bus.if_req & ~dm_win;
  // Grants are combinational but forced low while reset is held.
  assign dm_gnt_c = idle & dm_win & ~rst;
  assign if_gnt_c = idle & if_win & ~rst;

  // Next-state: arbitrate in IDLE, count down the busy window, capture read data on the last cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (dm_win) begin
          state_d = ST_BUSY_DM;
          cnt_d   = CW'(MEM_LAT - 1);
          en_d    = 1'b1;
          we_d    = bus.dm_we;
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
        end else if (if_win) begin
          state_d = ST_BUSY_IF;
          cnt_d   = CW'(MEM_LAT - 1);
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          we_d    = 1'b0;
          if (state_q == ST_BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            dm_rdata_d = we_q ? '0 : bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = ~idle;

endmodule
